cspi_master: RTL
================

Name: cspi_master

Overview:
- Chain-SPI frame source that sits directly upstream of the first cspi node in a chain.
- Takes a byte stream through a valid/ready handshake and drives one CS-framed burst of MSB-first serial data on CO_CS/CO_CK/CO_DAT.
- Each downstream node absorbs its share of the frame and passes the remaining clocks on.
- Clock rate is derived from clk by a programmable divider, so that oversampling receivers see clean edges.

Parameters:
- CLK_DIV, 4: CK half-period in clk cycles; legal range 2..255.
- CS_SETUP, 2: CK half-periods between CS falling and the first CK rising edge.
- CS_HOLD, 2: CK half-periods between the last CK falling edge and CS rising.
- GAP, 4: CK half-periods CS stays high after a frame before done/idle.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  frame request, sampled in IDLE only
- frame_bytes  input  12  number of bytes in the frame, latched on start
- abort  input  1  terminate the current frame
- tx_data  input  8  next byte to send
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  byte accepted when tx_valid && tx_ready
- busy  output  1  frame in progress (IDLE excluded)
- done  output  1  one-cycle pulse at the end of GAP
- bytes_sent  output  12  bytes fully shifted in the current/last frame
- CO_CS  output  1  chain chip-select, active low
- CO_CK  output  1  chain clock; data is sampled on its rising edge
- CO_DAT  output  1  chain data

Behaviour:
- Clock/reset: one clock (clk); asynchronous active-low reset (reset_n). All outputs are registered except tx_ready.
- Reset values: CO_CS=1, CO_CK=0, CO_DAT=0, busy=0, done=0, bytes_sent=0, tx_ready=0, state=IDLE.
- States: IDLE, SETUP, LOAD, SHIFT_LO, SHIFT_HI, HOLD, GAP. A single 8-bit half-period counter (hp_cnt) counts clk cycles, and a half-period repeat counter covers SETUP/HOLD/GAP.
- IDLE:
  - start=1 with frame_bytes!=0 → latch frame_bytes, clear bytes_sent, go to SETUP. On the next edge CO_CS=0 and busy=1.
  - start with frame_bytes==0 is ignored: no CS activity, no done.
- SETUP: CO_CK=0; lasts CS_SETUP*CLK_DIV cycles, then LOAD.
- LOAD:
  - tx_ready=1 (combinational, only in LOAD); CO_CK stays 0.
  - On handshake: shift_reg<=tx_data, CO_DAT<=tx_data[7], bit_cnt<=0, go to SHIFT_LO.
  - No tx_valid → stall in LOAD indefinitely with CK low and CS low. This underrun is legal; receivers are edge-driven.
- SHIFT_LO: CO_CK=0 for CLK_DIV cycles, then SHIFT_HI with CO_CK=1 (rising edge).
- SHIFT_HI: CO_CK=1 for CLK_DIV cycles. At the end, CO_CK<=0 (falling edge), and then:
  - bit_cnt<7: CO_DAT<=next bit (MSB first), bit_cnt+1, go to SHIFT_LO. Data therefore changes only on CK falling.
  - bit_cnt==7: bytes_sent+1. If bytes_sent+1 < frame_bytes go to LOAD, else HOLD.
- HOLD: CO_CK=0, CO_DAT held; lasts CS_HOLD*CLK_DIV cycles, then CO_CS<=1 and go to GAP.
- GAP: CS high for GAP*CLK_DIV cycles, then done=1 for one cycle, busy=0, go to IDLE.
- start while busy: ignored.
- abort in any non-IDLE state takes effect on the next edge:
  - CO_CK=0, CO_CS=1, go to GAP.
  - bytes_sent keeps its partial count; done still pulses at the end of GAP.
  - A byte offered in the same cycle as abort is not accepted: tx_ready is forced 0.
- Frame duration (no stalls): CO_CS low for (CS_SETUP + 16*frame_bytes + CS_HOLD)*CLK_DIV cycles plus one cycle per LOAD handshake.
- frame_bytes=4095 is legal. bytes_sent saturates naturally because the frame ends at frame_bytes.
- Reset mid-frame: outputs go to their reset values immediately (CO_CS=1 asynchronously).

Optional Feature:
- Macro: CSPI_MASTER_LSB_FIRST_EN.
- Defined: each byte is shifted LSB first; CO_DAT<=tx_data[0] at LOAD, shift right.
- Undefined: MSB first as specified above, which matches the cspi receiver's shift direction.

Test Plan:
- CLK_DIV=4, start with frame_bytes=2, bytes 0xA5,0x3C always valid → CO_CS low for (2+32+2)*4+2 = 146 cycles; 16 CK rising edges; sampled bits 10100101 00111100; done one pulse 16 cycles after CO_CS rises; bytes_sent=2.
- Same frame with tx_valid deasserted for 20 cycles before byte 2 → CK stays low and CS stays low during the stall; the serial bit sequence is unchanged; CS-low time becomes 146+20 cycles.
- start with frame_bytes=0 → CO_CS stays 1, busy stays 0, no done.
- abort asserted after the 5th CK rising edge of a 3-byte frame → next cycle CO_CS=1 and CO_CK=0; bytes_sent=0; done pulses after GAP*CLK_DIV=16 cycles.
- Chain check: cspi_master drives two cspi nodes (RX_BYTES=2 each) with a 4-byte frame 01 02 03 04 → node0 RAM holds 01,02; node1 RAM holds 03,04; both intr asserted.
- reset_n pulsed low in the middle of SHIFT_HI → CO_CS=1 and CO_CK=0 with no clk edge; start after release produces a normal frame.

Source files
------------

// File: rtl/cspi_master.sv
// cspi_master -- chain-SPI frame source.
//
// Accepts bytes over a valid/ready handshake and emits one CS-framed burst
// of serial data on CO_CS/CO_CK/CO_DAT for a chain of cspi nodes. CO_CK runs
// at clk/(2*CLK_DIV). Data changes only on CK falling and is sampled by the
// receivers on CK rising.
//
// Build option: define CSPI_MASTER_LSB_FIRST_EN to shift each byte LSB first
// (default is MSB first, matching the cspi receiver).
//
// Parameters:
//   CLK_DIV   CK half-period in clk cycles (2..255)
//   CS_SETUP  CK half-periods from CS falling to the first CK rising edge
//   CS_HOLD   CK half-periods from the last CK falling edge to CS rising
//   GAP       CK half-periods CS stays high before done / idle
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, frame_bytes    frame request (IDLE only) and its byte count
//   abort                 terminate the current frame
//   tx_data/valid/ready   byte stream input
//   busy, done            frame in progress / end-of-frame pulse
//   bytes_sent            bytes fully shifted in the current/last frame
//   CO_CS, CO_CK, CO_DAT  chain chip-select (active low), clock, data
module cspi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] frame_bytes,
  input  logic        abort,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [11:0] bytes_sent,
  output logic        CO_CS,
  output logic        CO_CK,
  output logic        CO_DAT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_GAP
  } state_t;

  // A zero repeat count still spends one half-period in the phase.
  localparam int SETUP_REPS = (CS_SETUP > 0) ? CS_SETUP : 1;
  localparam int HOLD_REPS  = (CS_HOLD  > 0) ? CS_HOLD  : 1;
  localparam int GAP_REPS   = (GAP      > 0) ? GAP      : 1;

  localparam logic [7:0] HP_LAST    = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_REPS - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_REPS - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_REPS - 1);

  state_t      state;
  logic [7:0]  hp_cnt;
  logic [7:0]  rep_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [11:0] frame_len;

  logic        hp_done;
  logic        start_ok;
  logic        load_ok;
  logic        shift_adv;
  logic        first_bit;
  logic        next_bit;
  logic [7:0]  shifted;

  assign hp_done = (hp_cnt == HP_LAST);

  // A byte offered together with abort is refused.
  assign tx_ready  = (state == ST_LOAD) && !abort;
  assign start_ok  = (state == ST_IDLE) && start && (frame_bytes != 12'd0);
  assign load_ok   = tx_valid && tx_ready;
  assign shift_adv = (state == ST_SHIFT_HI) && hp_done && (bit_cnt != 3'd7) && !abort;

`ifdef CSPI_MASTER_LSB_FIRST_EN
  assign first_bit = tx_data[0];
  assign next_bit  = shift_reg[1];
  assign shifted   = {1'b0, shift_reg[7:1]};
`else
  assign first_bit = tx_data[7];
  assign next_bit  = shift_reg[6];
  assign shifted   = {shift_reg[6:0], 1'b0};
`endif

  // Data registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      frame_len <= frame_bytes;
    end
    if (load_ok) begin
      shift_reg <= tx_data;
    end else if (shift_adv) begin
      shift_reg <= shifted;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hp_cnt     <= 8'd0;
      rep_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      CO_CS      <= 1'b1;
      CO_CK      <= 1'b0;
      CO_DAT     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= 12'd0;
    end else begin
      done <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        // Abort: release the chain at once and still run the full GAP.
        CO_CK   <= 1'b0;
        CO_CS   <= 1'b1;
        hp_cnt  <= 8'd0;
        rep_cnt <= 8'd0;
        state   <= ST_GAP;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              bytes_sent <= 12'd0;
              CO_CS      <= 1'b0;
              busy       <= 1'b1;
              hp_cnt     <= 8'd0;
              rep_cnt    <= 8'd0;
              state      <= ST_SETUP;
            end
          end

          ST_SETUP: begin
            if (hp_done) begin
              hp_cnt <= 8'd0;
              if (rep_cnt == SETUP_LAST) begin
                state <= ST_LOAD;
              end else begin
                rep_cnt <= rep_cnt + 8'd1;
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          ST_LOAD: begin
            // Without tx_valid the frame simply stalls here, CK low, CS low.
            if (load_ok) begin
              CO_DAT  <= first_bit;
              bit_cnt <= 3'd0;
              hp_cnt  <= 8'd0;
              state   <= ST_SHIFT_LO;
            end
          end

          ST_SHIFT_LO: begin
            if (hp_done) begin
              hp_cnt <= 8'd0;
              CO_CK  <= 1'b1;
              state  <= ST_SHIFT_HI;
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          ST_SHIFT_HI: begin
            if (hp_done) begin
              hp_cnt <= 8'd0;
              CO_CK  <= 1'b0;
              if (bit_cnt != 3'd7) begin
                CO_DAT  <= next_bit;
                bit_cnt <= bit_cnt + 3'd1;
                state   <= ST_SHIFT_LO;
              end else begin
                bytes_sent <= bytes_sent + 12'd1;
                if ((bytes_sent + 12'd1) < frame_len) begin
                  state <= ST_LOAD;
                end else begin
                  rep_cnt <= 8'd0;
                  state   <= ST_HOLD;
                end
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          ST_HOLD: begin
            if (hp_done) begin
              hp_cnt <= 8'd0;
              if (rep_cnt == HOLD_LAST) begin
                rep_cnt <= 8'd0;
                CO_CS   <= 1'b1;
                state   <= ST_GAP;
              end else begin
                rep_cnt <= rep_cnt + 8'd1;
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          ST_GAP: begin
            if (hp_done) begin
              hp_cnt <= 8'd0;
              if (rep_cnt == GAP_LAST) begin
                rep_cnt <= 8'd0;
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_IDLE;
              end else begin
                rep_cnt <= rep_cnt + 8'd1;
              end
            end else begin
              hp_cnt <= hp_cnt + 8'd1;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
